// File: rtl/burst_rr_arb_pkg.sv
// ============================================================================
// Module      : burst_rr_arb_pkg
// Description : Shared state encoding and modulo helper for burst_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package burst_rr_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Rotated priority encoder; first valid index starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    // Rotate so that bit 0 of w_rot corresponds to requester ptr.
    assign w_dbl = {req_valid, req_valid} >> ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];
    assign any   = |req_valid;

    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                if (int'(ptr) + k >= NUM_REQ) begin
                    idx = IDX_W'(int'(ptr) + k - NUM_REQ);
                end else begin
                    idx = IDX_W'(int'(ptr) + k);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/burst_rr_arbiter.sv
// ============================================================================
// Module      : burst_rr_arbiter
// Description : Round-robin arbiter with up to MAX_BURST back-to-back grants.
//               Optional counters enabled by BURST_RR_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_rr_arbiter
    import burst_rr_arb_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  MAX_BURST = 4,
    parameter int  CNT_W     = 16,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_idx,
    input  logic                     out_ready,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_e           r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [BURST_W-1:0]   r_burst;

    logic                 w_any;
    logic [IDX_W-1:0]     w_scan_idx;
    logic                 w_hold_ok;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (r_ptr),
        .any       (w_any),
        .idx       (w_scan_idx)
    );

    assign w_hold_ok = (r_state == ARB_HOLD) && req_valid[r_owner];
    assign w_sel     = w_hold_ok ? r_owner : w_scan_idx;
    assign out_valid = w_any && !rst;
    assign out_idx   = out_valid ? w_sel : '0;
    assign w_fire    = out_valid && out_ready;

    always_comb begin
        req_ready = '0;
        if (w_fire) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_fire) begin
                        if (MAX_BURST == 1) begin
                            r_ptr <= IDX_W'(wrap_inc(32'(w_sel), NUM_REQ));
                        end else begin
                            r_state <= ARB_HOLD;
                            r_owner <= w_sel;
                            r_burst <= BURST_W'(1);
                        end
                    end
                end
                ARB_HOLD: begin
                    if (w_hold_ok) begin
                        if (w_fire) begin
                            if (r_burst == BURST_W'(MAX_BURST - 1)) begin
                                r_state <= ARB_IDLE;
                                r_ptr   <= IDX_W'(wrap_inc(32'(r_owner), NUM_REQ));
                                r_burst <= '0;
                            end else begin
                                r_burst <= r_burst + BURST_W'(1);
                            end
                        end
                    end else begin
                        // Owner dropped: rotate past it; a same-cycle grant starts a new burst.
                        r_ptr <= IDX_W'(wrap_inc(32'(r_owner), NUM_REQ));
                        if (w_fire) begin
                            r_owner <= w_sel;
                            r_burst <= BURST_W'(1);
                        end else begin
                            r_state <= ARB_IDLE;
                            r_burst <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef BURST_RR_ARB_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (req_ready[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
        assign grant_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
    assign stall_cnt = r_stall_cnt;
`else
    assign grant_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_burst_rr_arbiter.sv
// ============================================================================
// Module      : tb_burst_rr_arbiter
// Description : Scoreboard bench for burst_rr_arbiter in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_burst_rr_arbiter;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
        logic [3:0] rdy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Config A: 4 requesters, burst 2
    logic [3:0]  a_req = '0, a_req_ready;
    logic        a_rdy = 1'b0, a_out_valid;
    logic [1:0]  a_out_idx;
    logic [63:0] a_grant_cnt;
    logic [15:0] a_stall_cnt;

    // Config B: 4 requesters, burst 4, 4-bit counters
    logic [3:0]  b_req = '0, b_req_ready;
    logic        b_rdy = 1'b0, b_out_valid;
    logic [1:0]  b_out_idx;
    logic [15:0] b_grant_cnt;
    logic [3:0]  b_stall_cnt;

    // Config C: 3 requesters, burst 1
    logic [2:0]  c_req = '0, c_req_ready;
    logic        c_rdy = 1'b0, c_out_valid;
    logic [1:0]  c_out_idx;
    logic [47:0] c_grant_cnt;
    logic [15:0] c_stall_cnt;

    burst_rr_arbiter #(.NUM_REQ(4), .MAX_BURST(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req), .req_ready(a_req_ready),
        .out_valid(a_out_valid), .out_idx(a_out_idx), .out_ready(a_rdy),
        .grant_cnt(a_grant_cnt), .stall_cnt(a_stall_cnt));

    burst_rr_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req), .req_ready(b_req_ready),
        .out_valid(b_out_valid), .out_idx(b_out_idx), .out_ready(b_rdy),
        .grant_cnt(b_grant_cnt), .stall_cnt(b_stall_cnt));

    burst_rr_arbiter #(.NUM_REQ(3), .MAX_BURST(1), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .req_valid(c_req), .req_ready(c_req_ready),
        .out_valid(c_out_valid), .out_idx(c_out_idx), .out_ready(c_rdy),
        .grant_cnt(c_grant_cnt), .stall_cnt(c_stall_cnt));

    task automatic test_reset();
        a_req = 4'hF;
        a_rdy = 1'b1;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_idx, a_req_ready} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got vld=%b idx=%0d rdy=%b want 0/0/0000",
                     a_out_valid, a_out_idx, a_req_ready);
        end
        checks++;
        if ({b_grant_cnt, b_stall_cnt} !== 20'h0) begin
            failures++;
            $display("FAIL reset_counters got grant=%h stall=%h want 0", b_grant_cnt, b_stall_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_rotation();
        int   seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        exp_t e;
        a_req = 4'hF;
        a_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{vld: 1'b1, idx: 2'(seq[i]), rdy: 4'(1 << seq[i])});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({a_out_valid, a_out_idx, a_req_ready} !== e) begin
                failures++;
                $display("FAIL rotation[%0d] got vld=%b idx=%0d rdy=%b want vld=%b idx=%0d rdy=%b",
                         i, a_out_valid, a_out_idx, a_req_ready, e.vld, e.idx, e.rdy);
            end
            @(posedge clk);
            #1;
        end
        a_req = '0;
    endtask

    task automatic test_async_reset();
        int   seq[2] = '{1, 0};
        exp_t e;
        a_req = 4'hF;
        a_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{vld: 1'b1, idx: 2'(seq[i]), rdy: 4'(1 << seq[i])});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({a_out_valid, a_out_idx, a_req_ready} !== e) begin
                failures++;
                $display("FAIL async_reset[%0d] got vld=%b idx=%0d rdy=%b want vld=%b idx=%0d rdy=%b",
                         i, a_out_valid, a_out_idx, a_req_ready, e.vld, e.idx, e.rdy);
            end
            @(posedge clk);
            if (i == 0) begin
                #3 rst = 1'b1;
                #1;
                checks++;
                if ({a_out_valid, a_out_idx, a_req_ready} !== 7'b0) begin
                    failures++;
                    $display("FAIL async_reset_outputs got vld=%b idx=%0d rdy=%b want 0/0/0000",
                             a_out_valid, a_out_idx, a_req_ready);
                end
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                #1;
            end
        end
        a_req = '0;
    endtask

    task automatic test_burst_break();
        logic [3:0] reqs[7] = '{4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1111, 4'b0000};
        int         seq[7]  = '{0, 2, 2, 2, 2, 3, 0};
        exp_t       e;
        b_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_req = reqs[i];
            if (i == 6) sb.push_back('{vld: 1'b0, idx: 2'd0, rdy: 4'b0});
            else        sb.push_back('{vld: 1'b1, idx: 2'(seq[i]), rdy: 4'(1 << seq[i])});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({b_out_valid, b_out_idx, b_req_ready} !== e) begin
                failures++;
                $display("FAIL burst_break[%0d] got vld=%b idx=%0d rdy=%b want vld=%b idx=%0d rdy=%b",
                         i, b_out_valid, b_out_idx, b_req_ready, e.vld, e.idx, e.rdy);
            end
            @(posedge clk);
            #1;
            if (i == 1) begin
                checks++;
                if (dut_b.r_ptr !== 2'd1) begin
                    failures++;
                    $display("FAIL break_ptr got %0d want 1", dut_b.r_ptr);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic ready[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_t e;
        logic [3:0] exp_stall;
`ifdef BURST_RR_ARB_PERF_EN
        exp_stall = 4'd3;
`else
        exp_stall = 4'd0;
`endif
        b_req = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            b_rdy = ready[i];
            sb.push_back('{vld: 1'b1, idx: 2'd1, rdy: ready[i] ? 4'b0010 : 4'b0000});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({b_out_valid, b_out_idx, b_req_ready} !== e) begin
                failures++;
                $display("FAIL backpressure[%0d] got vld=%b idx=%0d rdy=%b want vld=%b idx=%0d rdy=%b",
                         i, b_out_valid, b_out_idx, b_req_ready, e.vld, e.idx, e.rdy);
            end
            if (i == 3) begin
                checks++;
                if (b_stall_cnt !== exp_stall) begin
                    failures++;
                    $display("FAIL stall_cnt got %0d want %0d", b_stall_cnt, exp_stall);
                end
            end
            if (i == 5) begin
                checks++;
                if (dut_b.r_burst !== 3'd1) begin
                    failures++;
                    $display("FAIL stall_burst got %0d want 1", dut_b.r_burst);
                end
            end
            @(posedge clk);
            #1;
        end
        b_req = '0;
        b_rdy = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        exp_t        e;
        logic [15:0] exp_grant;
        logic [3:0]  exp_stall;
`ifdef BURST_RR_ARB_PERF_EN
        exp_grant = 16'h142F;
        exp_stall = 4'd5;
`else
        exp_grant = 16'h0000;
        exp_stall = 4'd0;
`endif
        b_req = 4'b0001;
        b_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sb.push_back('{vld: 1'b1, idx: 2'd0, rdy: 4'b0001});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({b_out_valid, b_out_idx, b_req_ready} !== e) begin
                failures++;
                $display("FAIL saturation[%0d] got vld=%b idx=%0d rdy=%b want vld=%b idx=%0d rdy=%b",
                         i, b_out_valid, b_out_idx, b_req_ready, e.vld, e.idx, e.rdy);
            end
            @(posedge clk);
            #1;
        end
        b_req = '0;
        @(negedge clk);
        checks++;
        if (b_grant_cnt !== exp_grant) begin
            failures++;
            $display("FAIL grant_cnt got %h want %h", b_grant_cnt, exp_grant);
        end
        checks++;
        if (b_stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL stall_total got %0d want %0d", b_stall_cnt, exp_stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        int   seq[5] = '{0, 1, 2, 0, 1};
        exp_t e;
        c_req = 3'b111;
        c_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{vld: 1'b1, idx: 2'(seq[i]), rdy: 4'(1 << seq[i])});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({c_out_valid, c_out_idx, 1'b0, c_req_ready} !== e) begin
                failures++;
                $display("FAIL wrap[%0d] got vld=%b idx=%0d rdy=%b want vld=%b idx=%0d rdy=%b",
                         i, c_out_valid, c_out_idx, c_req_ready, e.vld, e.idx, e.rdy);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (dut_c.r_ptr !== 2'd2) begin
            failures++;
            $display("FAIL wrap_ptr got %0d want 2", dut_c.r_ptr);
        end
        c_req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rotation();
        test_async_reset();
        test_burst_break();
        test_backpressure();
        test_saturation();
        test_wrap();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/burst_rr_arbiter.md
# burst_rr_arbiter

- Round-robin arbiter that shares one downstream consumer between `NUM_REQ` upstream event sources.
- Typical sources are FIFO pop ports or trigger counters; the typical consumer is a single-issue execution stage.
- Grants one transfer per cycle and may keep the current owner for up to `MAX_BURST` back-to-back transfers before rotating.
- Sits between the per-requester queues and the shared stage, and drives each queue's pop handshake.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2, any integer (need not be a power of two).
- `MAX_BURST`, 4: max consecutive grants to one owner, ≥1.
- `CNT_W`, 16: width of the performance counters (used only with `BURST_RR_ARB_PERF_EN`).
- `IDX_W`, localparam: `$clog2(NUM_REQ)`.

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  NUM_REQ  per-requester "has an event" (source pop_valid).
- `req_ready`  out  NUM_REQ  per-requester pop strobe (source pop_ready); one-hot or zero.
- `out_valid`  out  1  a granted event is offered downstream.
- `out_idx`  out  IDX_W  index of the granted requester.
- `out_ready`  in  1  downstream accepts this cycle.
- `grant_cnt`  out  NUM_REQ*CNT_W  per-requester accepted-transfer count, requester i at bits [i*CNT_W +: CNT_W] (perf only).
- `stall_cnt`  out  CNT_W  cycles with out_valid && !out_ready (perf only).

## Operation

- State: `state` ∈ {ARB_IDLE, ARB_HOLD}; `ptr` (IDX_W bits, next-priority index); `owner` (IDX_W bits); `burst` (width clog2(MAX_BURST+1)).
- Selection, combinational from `req_valid` and registered state only:
  - In ARB_HOLD with `req_valid[owner]`: `sel = owner`.
  - Otherwise, `sel` is the first valid index scanning `ptr, ptr+1, …` modulo NUM_REQ.
- `out_valid = |req_valid` (forced 0 while `rst`). `out_idx = sel`, or 0 when `!out_valid`.
- `fire = out_valid && out_ready`. `req_ready[i] = fire && (sel == i)`; all zero otherwise.
- Transitions, on the clock edge:
  - ARB_IDLE, fire on k:
    - If MAX_BURST == 1: stay ARB_IDLE, `ptr = k+1` (mod NUM_REQ).
    - Else: go to ARB_HOLD, `owner = k`, `burst = 1`.
  - ARB_HOLD, fire on owner:
    - `burst+1 == MAX_BURST`: go to ARB_IDLE, `ptr = owner+1` (mod NUM_REQ), `burst = 0`.
    - Else: `burst++`.
  - ARB_HOLD, `!req_valid[owner]`: the burst breaks.
    - Go to ARB_IDLE, `ptr = owner+1`.
    - If another requester fires this same cycle, that fire is handled as the ARB_IDLE case (new owner, `burst = 1`).
  - No fire and owner still valid (or state is ARB_IDLE): state is unchanged.
- Modulo arithmetic: `ptr == NUM_REQ-1` increments to 0, never to NUM_REQ.
- Reset, asynchronous, at any time including mid-burst:
  - `state = ARB_IDLE`, `ptr = 0`, `owner = 0`, `burst = 0`, perf counters = 0.
  - Outputs during reset: `out_valid = 0`, `req_ready = 0`, `out_idx = 0`.

## Timing

- Zero-cycle grant: a valid request can fire in the same cycle it is raised.
- State updates take effect on the next edge.
- No combinational path from `out_ready` to `out_idx` or `out_valid`. `out_ready` reaches `req_ready` only.
- Under stall (`out_valid && !out_ready`), `out_idx` stays stable as long as `req_valid` is unchanged.
- Max consecutive grants to one requester while others wait: MAX_BURST.
- Worst-case wait for any continuously valid requester: (NUM_REQ-1)*MAX_BURST transfers.

## Configuration

- `BURST_RR_ARB_PERF_EN` defined:
  - `grant_cnt[i]` increments on `req_ready[i]`.
  - `stall_cnt` increments on `out_valid && !out_ready`.
  - Both saturate at all-ones and never wrap.
- Undefined: no counter registers exist, and `grant_cnt` / `stall_cnt` are tied to 0.
- Arbitration behaviour is identical in both builds.

## Structure

- Package `burst_rr_arb_pkg`: enum `arb_state_e {ARB_IDLE, ARB_HOLD}` and a `wrap_inc(idx, n)` function for the modulo increment.
- Sub-module `rr_pick`: a rotated priority encoder with inputs `req_valid` and `ptr`, and outputs `any` and `idx`. It is purely combinational and parameterised by NUM_REQ.

## Test plan

- Reset: hold `rst=1` with all `req_valid=1` and `out_ready=1` → `out_valid=0`, `req_ready=0`. After release, the first grant is idx 0.
- NUM_REQ=4, MAX_BURST=2, all valid, `out_ready=1` → `out_idx` sequence 0,0,1,1,2,2,3,3,0,0.
- Burst break: MAX_BURST=4, req0 valid for 1 cycle, req2 always valid → grants 0 then 2,2,2,2; `ptr` after the break is 1.
- Backpressure: only req1 valid, `out_ready=0` for 3 cycles → `out_idx=1` stable, `req_ready=0`, `burst` unchanged, `stall_cnt=3`. Then `out_ready=1` → `req_ready=4'b0010`.
- Wrap: NUM_REQ=3, MAX_BURST=1, all valid → 0,1,2,0,1; `ptr` never reaches 3.
- Perf saturation: CNT_W=4, req0 granted 20 times → `grant_cnt[0]=15`. Build without `BURST_RR_ARB_PERF_EN` → counters read 0.
